ps2_key_arbiter: RTL
====================

PS2_KEY_ARBITER -- requirements
Module: ps2_key_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2500000, meaning the maximum idle cycles inside a partial scan-code sequence (100 ms at 25 MHz).
REQ-002 SHALL have port Master_Clock_In, input, 1, the single 25 MHz clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_N_In, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port Byte_In, input, 8, the received PS/2 scan-code byte.
REQ-005 SHALL have port Byte_Valid_In, input, 1, the byte strobe; every high cycle consumes one byte.
REQ-006 SHALL have port P1_Keys_Out, output, 5, player-1 held keys, registered, with bit mapping {4 Fire, 3 Down, 2 Right, 1 Left, 0 Up}.
REQ-007 SHALL have port P2_Keys_Out, output, 5, player-2 held keys, registered, with the same bit mapping.
REQ-008 SHALL have port Key_Event_Out, output, 1, a one-cycle pulse when a mapped make or break code is applied.
REQ-009 SHALL have port Error_Out, output, 1, a one-cycle pulse on a protocol error or timeout.

Function
REQ-010 SHALL implement FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-011 IDLE transitions SHALL be: E0 -> EXT; F0 -> BRK; AA/00/FF -> clear both key vectors, stay IDLE; any other byte -> apply normal make, stay IDLE.
REQ-012 EXT transitions SHALL be: F0 -> EXT_BRK; E0 -> stay EXT, no error; any other byte -> apply extended make, go IDLE.
REQ-013 BRK transitions SHALL be: E0 or F0 -> Error_Out pulse, go IDLE; any other byte -> apply normal break, go IDLE.
REQ-014 EXT_BRK transitions SHALL be: E0 or F0 -> Error_Out pulse, go IDLE; any other byte -> apply extended break, go IDLE.
REQ-015 Normal code mapping SHALL drive P1: 1D Up, 1C Left, 23 Right, 1B Down, 29 Fire.
REQ-016 Extended code mapping SHALL drive P2: E0 75 Up, E0 6B Left, E0 74 Right, E0 72 Down, E0 14 Fire.
REQ-017 Unmapped codes SHALL change no key bit and SHALL NOT pulse Key_Event_Out; E1 sequences thereby pass harmlessly.
REQ-018 A make SHALL set its bit and a break SHALL clear its bit; a repeated make (typematic) SHALL leave the bit at 1 and still pulse Key_Event_Out.
REQ-019 Latency: the key outputs and Key_Event_Out SHALL change on the first rising edge at which Byte_Valid_In is sampled high with the final byte of the sequence.
REQ-020 A 22-bit timeout counter SHALL reset to 0 on every consumed byte and increment each cycle while the state is not IDLE.
REQ-021 When the counter reaches TIMEOUT_CYCLES-1 in a non-IDLE state, the FSM SHALL go to IDLE and pulse Error_Out; the key vectors SHALL remain unchanged.
REQ-022 If a byte is valid on the expiry cycle, the byte SHALL win: it is processed in the current state, and there is no timeout and no Error_Out.
REQ-023 The counter SHALL hold at 0 in IDLE and SHALL never wrap.
REQ-024 P1 and P2 updates SHALL be independent; a P1 make SHALL never alter P2 bits, and vice versa.

Reset
REQ-025 While Reset_N_In=0, the block SHALL immediately force state IDLE, counter 0, P1_Keys_Out=00000, P2_Keys_Out=00000, Key_Event_Out=0, Error_Out=0.
REQ-026 Reset asserted mid-sequence (for example after E0) SHALL discard the partial sequence; after release, the next byte SHALL be decoded from IDLE.

Verification
REQ-027 SHALL cover: bytes 1D, 29 -> P1_Keys_Out=10001 with two Key_Event_Out pulses; then F0 1D -> P1_Keys_Out=10000.
REQ-028 SHALL cover: bytes E0 75, E0 14 -> P2_Keys_Out=10001, P1 unchanged; then E0 F0 75 -> P2_Keys_Out=10000.
REQ-029 SHALL cover: byte E0 followed by TIMEOUT_CYCLES idle cycles -> one Error_Out pulse, state IDLE; a following 75 -> no P2 change (treated as unmapped normal code).
REQ-030 SHALL cover: byte F0 then E0 -> Error_Out pulse, key vectors unchanged; then byte 1B -> P1 Down=1.
REQ-031 SHALL cover: keys held in both vectors, then byte AA -> both vectors 00000 one cycle after the strobe.
REQ-032 SHALL cover: Reset_N_In pulsed low between E0 and F0 -> outputs 0 asynchronously; then F0 1C after release -> treated as a normal break, Left stays 0.

Source files
------------

// File: rtl/ps2_key_arbiter.sv
// ---------------------------------------------------------------------------
// ps2_key_arbiter
//
// Decodes a stream of PS/2 set-2 scan-code bytes into two independent
// five-key "held" vectors, one per player. Player 1 uses plain codes, player 2
// uses E0-prefixed (extended) codes. A small FSM tracks the E0 / F0 prefixes;
// a watchdog counter abandons a partial sequence that stalls for too long.
//
// Ports
//   Master_Clock_In  in   1  single clock, all state changes on rising edge
//   Reset_N_In       in   1  asynchronous active-low reset
//   Byte_In          in   8  received scan-code byte
//   Byte_Valid_In    in   1  byte strobe, each high cycle consumes one byte
//   P1_Keys_Out      out  5  player-1 held keys {Fire, Down, Right, Left, Up}
//   P2_Keys_Out      out  5  player-2 held keys, same bit mapping
//   Key_Event_Out    out  1  one-cycle pulse when a mapped make/break applies
//   Error_Out        out  1  one-cycle pulse on protocol error or timeout
// ---------------------------------------------------------------------------
module ps2_key_arbiter #(
    // Maximum idle cycles allowed inside a partial sequence (100 ms @ 25 MHz).
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    input  logic [7:0] Byte_In,
    input  logic       Byte_Valid_In,
    output logic [4:0] P1_Keys_Out,
    output logic [4:0] P2_Keys_Out,
    output logic       Key_Event_Out,
    output logic       Error_Out
);

    // Prefix and special codes.
    localparam logic [7:0] CODE_EXT      = 8'hE0;
    localparam logic [7:0] CODE_BREAK    = 8'hF0;
    localparam logic [7:0] CODE_BAT_OK   = 8'hAA;
    localparam logic [7:0] CODE_OVERRUN0 = 8'h00;
    localparam logic [7:0] CODE_OVERRUNF = 8'hFF;

    // Key bit positions shared by both players.
    localparam int KEY_UP    = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_FIRE  = 4;

    // Last counter value before the sequence is abandoned.
    localparam logic [21:0] TIMEOUT_LAST = 22'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,  // E0 seen
        ST_BRK     = 2'd2,  // F0 seen
        ST_EXT_BRK = 2'd3   // E0 F0 seen
    } state_e;

    state_e      state_q;
    logic [21:0] timer_q;
    logic [4:0]  p1_q;
    logic [4:0]  p2_q;
    logic        key_event_q;
    logic        error_q;

    // -----------------------------------------------------------------------
    // Byte classification
    // -----------------------------------------------------------------------
    logic       is_ext;
    logic       is_break;
    logic       is_clear;
    logic [4:0] norm_mask;  // one-hot P1 key for a plain code, 0 if unmapped
    logic [4:0] ext_mask;   // one-hot P2 key for an extended code, 0 if unmapped

    assign is_ext   = (Byte_In == CODE_EXT);
    assign is_break = (Byte_In == CODE_BREAK);
    // Keyboard self-test pass and overrun codes mean our view of held keys
    // can no longer be trusted, so both vectors are dropped.
    assign is_clear = (Byte_In == CODE_BAT_OK)   ||
                      (Byte_In == CODE_OVERRUN0) ||
                      (Byte_In == CODE_OVERRUNF);

    always_comb begin
        norm_mask = '0;
        case (Byte_In)
            8'h1D:   norm_mask[KEY_UP]    = 1'b1;  // W
            8'h1C:   norm_mask[KEY_LEFT]  = 1'b1;  // A
            8'h23:   norm_mask[KEY_RIGHT] = 1'b1;  // D
            8'h1B:   norm_mask[KEY_DOWN]  = 1'b1;  // S
            8'h29:   norm_mask[KEY_FIRE]  = 1'b1;  // Space
            default: norm_mask = '0;
        endcase
    end

    always_comb begin
        ext_mask = '0;
        case (Byte_In)
            8'h75:   ext_mask[KEY_UP]    = 1'b1;  // cursor up
            8'h6B:   ext_mask[KEY_LEFT]  = 1'b1;  // cursor left
            8'h74:   ext_mask[KEY_RIGHT] = 1'b1;  // cursor right
            8'h72:   ext_mask[KEY_DOWN]  = 1'b1;  // cursor down
            8'h14:   ext_mask[KEY_FIRE]  = 1'b1;  // right ctrl
            default: ext_mask = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequence FSM, watchdog and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: every register here is updated with non-blocking assignments so
    // all branches read the pre-edge values of state_q, p1_q and p2_q.
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            // NOTE: the asynchronous reset covers every state bit, including
            // the key vectors, so a partial sequence can never survive reset.
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            key_event_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // NOTE: pulses default low here and are overridden below; the
            // last non-blocking assignment in the block wins.
            key_event_q <= 1'b0;
            error_q     <= 1'b0;

            if (Byte_Valid_In) begin
                // A byte always beats an expiring watchdog on the same cycle.
                timer_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (is_ext) begin
                            state_q <= ST_EXT;
                        end else if (is_break) begin
                            state_q <= ST_BRK;
                        end else if (is_clear) begin
                            p1_q <= '0;
                            p2_q <= '0;
                        end else begin
                            p1_q        <= p1_q | norm_mask;
                            key_event_q <= |norm_mask;
                        end
                    end

                    ST_EXT: begin
                        if (is_break) begin
                            state_q <= ST_EXT_BRK;
                        end else if (is_ext) begin
                            // Repeated E0 is tolerated; keep waiting.
                            state_q <= ST_EXT;
                        end else begin
                            p2_q        <= p2_q | ext_mask;
                            key_event_q <= |ext_mask;
                            state_q     <= ST_IDLE;
                        end
                    end

                    ST_BRK: begin
                        if (is_ext || is_break) begin
                            error_q <= 1'b1;
                        end else begin
                            p1_q        <= p1_q & ~norm_mask;
                            key_event_q <= |norm_mask;
                        end
                        state_q <= ST_IDLE;
                    end

                    ST_EXT_BRK: begin
                        if (is_ext || is_break) begin
                            error_q <= 1'b1;
                        end else begin
                            p2_q        <= p2_q & ~ext_mask;
                            key_event_q <= |ext_mask;
                        end
                        state_q <= ST_IDLE;
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q == ST_IDLE) begin
                timer_q <= '0;
            end else if (timer_q == TIMEOUT_LAST) begin
                // Stalled prefix: drop it, keep the held keys as they are.
                state_q <= ST_IDLE;
                timer_q <= '0;
                error_q <= 1'b1;
            end else begin
                timer_q <= timer_q + 22'd1;
            end
        end
    end

    assign P1_Keys_Out   = p1_q;
    assign P2_Keys_Out   = p2_q;
    assign Key_Event_Out = key_event_q;
    assign Error_Out     = error_q;

endmodule
